spectrum_bin_sequencer: RTL and testbench

- Per-frame scheduler for the FFT result optimizer (magnitude → sqrt → log-bar chain), which accepts one bin per Start/End handshake.
- After the FFT core signals a completed stereo frame, walks every bin of channel L then channel R and reads Re/Im from the FFT result RAM.
- Launches one optimizer conversion per bin, waits for its End, and writes the 7-bit Spectol into the display spectrum RAM.
- Supervises the optimizer with a watchdog and reports frame status to the display controller.

---
 rtl/spectrum_bin_sequencer.sv | 177 +++++++++++++++++
 tb/tb_spectrum_bin_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_bin_sequencer.sv
// rtl/spectrum_bin_sequencer.sv - per-frame FFT bin scheduler feeding the spectrum optimizer
// Optional falling-peak display hold: define SPC_PEAK_HOLD_EN.
module spectrum_bin_sequencer #(
    parameter int NUM_BINS = 64,
    parameter int ADDR_W   = 6,
    parameter int TIMEOUT  = 255
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              FrameReady,
    input  logic              ClearStatus,
    output logic [ADDR_W:0]   FftAddr,
    input  logic [17:0]       FftRe,
    input  logic [17:0]       FftIm,
    output logic              OptStart,
    output logic [17:0]       OptRe,
    output logic [17:0]       OptIm,
    input  logic [6:0]        OptSpectol,
    input  logic              OptEnd,
    output logic              SpcWe,
    output logic [ADDR_W:0]   SpcAddr,
    output logic [6:0]        SpcData,
    output logic              Busy,
    output logic              FrameDone,
    output logic              Overrun,
    output logic              Timeout
);
    localparam int AW   = ADDR_W + 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(2 * NUM_BINS - 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_LATCH, S_LAUNCH, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     fft_addr_q, fft_addr_d;
    logic [17:0]       opt_re_q, opt_re_d, opt_im_q, opt_im_d;
    logic              opt_start_q, opt_start_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              spc_we_q, spc_we_d;
    logic [AW-1:0]     spc_addr_q, spc_addr_d;
    logic [6:0]        spc_data_q, spc_data_d;
    logic              busy_q, busy_d, frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d, timeout_q, timeout_d;
    logic              capture;
    logic [6:0]        raw_val, spc_val;

    // An abandoned bin is written as silence.
    assign raw_val = OptEnd ? OptSpectol : 7'd0;

`ifdef SPC_PEAK_HOLD_EN
    logic [6:0] peak_q [2*NUM_BINS];
    logic [6:0] held_dec;

    assign held_dec = (peak_q[fft_addr_q] == 7'd0) ? 7'd0 : peak_q[fft_addr_q] - 7'd1;
    assign spc_val  = (raw_val > held_dec) ? raw_val : held_dec;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 2 * NUM_BINS; i++) peak_q[i] <= 7'd0;
        end else if (capture) begin
            peak_q[fft_addr_q] <= spc_val;
        end
    end
`else
    assign spc_val = raw_val;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            fft_addr_q   <= '0;
            opt_re_q     <= '0;
            opt_im_q     <= '0;
            opt_start_q  <= 1'b0;
            wd_q         <= '0;
            spc_we_q     <= 1'b0;
            spc_addr_q   <= '0;
            spc_data_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fft_addr_q   <= fft_addr_d;
            opt_re_q     <= opt_re_d;
            opt_im_q     <= opt_im_d;
            opt_start_q  <= opt_start_d;
            wd_q         <= wd_d;
            spc_we_q     <= spc_we_d;
            spc_addr_q   <= spc_addr_d;
            spc_data_q   <= spc_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fft_addr_d   = fft_addr_q;
        opt_re_d     = opt_re_q;
        opt_im_d     = opt_im_q;
        opt_start_d  = 1'b0;
        wd_d         = wd_q;
        spc_we_d     = 1'b0;
        spc_addr_d   = spc_addr_q;
        spc_data_d   = spc_data_q;
        frame_done_d = 1'b0;
        capture      = 1'b0;
        // Busy stays up through the FrameDone cycle so a frame never restarts on top of its own completion.
        busy_d       = busy_q & ~frame_done_q;
        overrun_d    = overrun_q & ~ClearStatus;
        timeout_d    = timeout_q & ~ClearStatus;
        if (FrameReady && busy_q) overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (FrameReady && !busy_q) begin
                    busy_d     = 1'b1;
                    fft_addr_d = '0;
                    state_d    = S_READ;
                end
            end
            S_READ:  state_d = S_LATCH;
            S_LATCH: begin
                opt_re_d = FftRe;
                opt_im_d = FftIm;
                state_d  = S_LAUNCH;
            end
            S_LAUNCH: begin
                opt_start_d = 1'b1;
                wd_d        = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (OptEnd || wd_q == WD_LAST) begin
                    capture    = 1'b1;
                    timeout_d  = timeout_d | ~OptEnd;
                    spc_we_d   = 1'b1;
                    spc_addr_d = fft_addr_q;
                    spc_data_d = spc_val;
                    state_d    = S_WRITE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (fft_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    fft_addr_d = fft_addr_q + 1'b1;
                    state_d    = S_READ;
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign FftAddr   = fft_addr_q;
    assign OptStart  = opt_start_q;
    assign OptRe     = opt_re_q;
    assign OptIm     = opt_im_q;
    assign SpcWe     = spc_we_q;
    assign SpcAddr   = spc_addr_q;
    assign SpcData   = spc_data_q;
    assign Busy      = busy_q;
    assign FrameDone = frame_done_q;
    assign Overrun   = overrun_q;
    assign Timeout   = timeout_q;
endmodule

// File: tb/tb_spectrum_bin_sequencer.sv
// tb/tb_spectrum_bin_sequencer.sv - self-checking bench for spectrum_bin_sequencer
module tb_spectrum_bin_sequencer;
    localparam int NA = 128;
    localparam int TO = 255;

    logic        Clock = 1'b0;
    logic        Reset, FrameReady, ClearStatus;
    logic [6:0]  FftAddr, SpcAddr, SpcData, OptSpectol;
    logic [17:0] FftRe, FftIm, OptRe, OptIm;
    logic        OptStart, OptEnd, SpcWe, Busy, FrameDone, Overrun, Timeout;

    spectrum_bin_sequencer dut (
        .Clock(Clock), .Reset(Reset), .FrameReady(FrameReady), .ClearStatus(ClearStatus),
        .FftAddr(FftAddr), .FftRe(FftRe), .FftIm(FftIm),
        .OptStart(OptStart), .OptRe(OptRe), .OptIm(OptIm),
        .OptSpectol(OptSpectol), .OptEnd(OptEnd),
        .SpcWe(SpcWe), .SpcAddr(SpcAddr), .SpcData(SpcData),
        .Busy(Busy), .FrameDone(FrameDone), .Overrun(Overrun), .Timeout(Timeout)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int lat;       // optimizer latency, -1 = random per bin
        int hang;      // bin that never gets OptEnd, -1 = none
        int dup;       // bin at which FrameReady is re-pulsed, 200 = DONE cycle, -1 = none
        bit clr;       // pulse ClearStatus together with the re-pulse
        int mode;      // RAM contents pattern
        int exp_busy;  // expected Busy cycles, 0 = take from model
        bit exp_to;
        bit exp_ov;
    } vec_t;
    vec_t vecs[9];

    logic [17:0] ram_re[NA], ram_im[NA];
    int          lat_arr[NA];
    int          hang_bin = -1;
    int          peak_b3;
    logic [6:0]  held[NA];
    logic [6:0]  exp_data[NA];
    int          total = 0, bad = 0;

    function automatic logic [6:0] opt_f(input logic [17:0] re, input logic [17:0] im);
        return re[6:0] + im[6:0];
    endfunction

    // Result RAM: data reflects the address presented one cycle earlier.
    logic [6:0] addr_prev;
    always @(negedge Clock) begin
        FftRe = ram_re[addr_prev];
        FftIm = ram_im[addr_prev];
        addr_prev = FftAddr;
    end

    // Optimizer: answers after lat_arr cycles, emits stray OptEnd pulses when idle.
    int opt_err = 0, cnt, st_cnt = 0;
    bit pend, in_hang, prev_start;
    logic [17:0] s_re, s_im;
    always @(negedge Clock) begin
        OptEnd = 1'b0;
        OptSpectol = 7'($urandom);
        if (Reset) begin
            pend = 0; in_hang = 0; prev_start = 0;
        end else begin
            if (OptStart && prev_start) opt_err++;
            if (OptStart) begin
                st_cnt++;
                if (OptRe !== ram_re[FftAddr] || OptIm !== ram_im[FftAddr]) opt_err++;
                s_re = OptRe; s_im = OptIm; pend = 0; in_hang = 0;
                if (int'(FftAddr) == hang_bin) in_hang = 1;
                else if (lat_arr[FftAddr] == 0) begin
                    OptEnd = 1'b1; OptSpectol = opt_f(OptRe, OptIm);
                end else begin
                    cnt = lat_arr[FftAddr]; pend = 1;
                end
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    OptEnd = 1'b1; OptSpectol = opt_f(OptRe, OptIm); pend = 0;
                    if (OptRe !== s_re || OptIm !== s_im) opt_err++;
                end
            end else if (!in_hang && $urandom_range(0, 3) == 0) begin
                OptEnd = 1'b1; OptSpectol = 7'h55;
            end
            prev_start = OptStart;
        end
    end

    logic [6:0] wa[$], wd[$];
    int busy_cnt = 0, done_cnt = 0;
    always @(negedge Clock) begin
        if (SpcWe) begin wa.push_back(SpcAddr); wd.push_back(SpcData); end
        if (Busy) busy_cnt++;
        if (FrameDone) done_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic prep(input int r);
        for (int a = 0; a < NA; a++) begin
            case (vecs[r].mode)
                0: begin ram_re[a] = 18'(a); ram_im[a] = '0; end
                1: begin ram_re[a] = 18'($urandom); ram_im[a] = 18'($urandom); end
                2: if (a == 5) begin ram_re[a] = 18'h1FFFF; ram_im[a] = 18'h20000; end
                   else begin ram_re[a] = 18'($urandom); ram_im[a] = 18'($urandom); end
                default: begin ram_re[a] = (a == 3) ? 18'(peak_b3) : '0; ram_im[a] = '0; end
            endcase
            lat_arr[a] = (vecs[r].lat < 0) ? int'($urandom_range(0, 6)) : vecs[r].lat;
        end
        hang_bin = vecs[r].hang;
    endtask

    task automatic run_frame(input int r);
        vec_t v;
        int wbase, bbase, dbase, ebase, cyc, expb;
        bit fired, arm;
        logic [6:0] nv, d;
        v = vecs[r];
        prep(r);
        expb = 2;
        for (int a = 0; a < NA; a++) begin
            expb += (a == v.hang) ? TO + 4 : 5 + lat_arr[a];
            nv = (a == v.hang) ? 7'd0 : opt_f(ram_re[a], ram_im[a]);
`ifdef SPC_PEAK_HOLD_EN
            d = (held[a] == 7'd0) ? 7'd0 : held[a] - 7'd1;
            nv = (nv > d) ? nv : d;
            held[a] = nv;
`else
            d = nv;
`endif
            exp_data[a] = d;
        end
        if (v.exp_busy != 0) expb = v.exp_busy;
        wbase = wa.size(); bbase = busy_cnt; dbase = done_cnt; ebase = opt_err;
        @(negedge Clock); FrameReady = 1'b1;
        @(negedge Clock); FrameReady = 1'b0;
        fired = 0; arm = 0; cyc = 0;
        while (done_cnt == dbase && cyc < 20000) begin
            @(negedge Clock); cyc++;
            FrameReady = 1'b0; ClearStatus = 1'b0;
            if (arm) begin FrameReady = 1'b1; arm = 0; fired = 1; end
            else if (!fired && v.dup == 200 && SpcWe && SpcAddr == 7'd127) arm = 1;
            else if (!fired && v.dup >= 0 && v.dup < NA && Busy && int'(FftAddr) == v.dup) begin
                FrameReady = 1'b1; ClearStatus = v.clr; fired = 1;
            end
        end
        FrameReady = 1'b0; ClearStatus = 1'b0;
        repeat (4) @(negedge Clock);
        chk($sformatf("frame_finished[%0d]", r), cyc < 20000, 1);
        chk($sformatf("write_count[%0d]", r), wa.size() - wbase, NA);
        for (int i = 0; i < NA; i++) begin
            if (wbase + i < wa.size()) begin
                chk($sformatf("write_addr[%0d]", i), wa[wbase + i], i);
                chk($sformatf("write_data[%0d]", i), wd[wbase + i], exp_data[i]);
            end
        end
        chk($sformatf("frame_done_pulses[%0d]", r), done_cnt - dbase, 1);
        chk($sformatf("busy_cycles[%0d]", r), busy_cnt - bbase, expb);
        chk($sformatf("timeout_flag[%0d]", r), Timeout, v.exp_to);
        chk($sformatf("overrun_flag[%0d]", r), Overrun, v.exp_ov);
        chk($sformatf("busy_after[%0d]", r), Busy, 0);
        chk($sformatf("opt_operands[%0d]", r), opt_err - ebase, 0);
        ClearStatus = 1'b1;
        @(negedge Clock); ClearStatus = 1'b0;
        chk($sformatf("status_cleared[%0d]", r), {Overrun, Timeout}, 0);
    endtask

    initial begin
        int cyc, wb, sb;
        int pk[3];
        pk = '{100, 99, 98};
        Reset = 1'b1; FrameReady = 1'b0; ClearStatus = 1'b0; peak_b3 = 0;
        for (int a = 0; a < NA; a++) held[a] = '0;
        vecs[0] = '{4, -1, -1, 0, 0, 1154, 0, 0};
        vecs[1] = '{0, -1, -1, 0, 1, 642, 0, 0};
        vecs[2] = '{2, 10, -1, 0, 2, 1150, 1, 0};
        vecs[3] = '{3, -1, 40, 0, 0, 1026, 0, 1};
        vecs[4] = '{-1, -1, -1, 0, 1, 0, 0, 0};
        vecs[5] = '{-1, 127, -1, 0, 1, 0, 1, 0};
        vecs[6] = '{1, -1, 20, 1, 1, 770, 0, 1};
        vecs[7] = '{2, -1, 200, 0, 1, 898, 0, 1};
        vecs[8] = '{1, -1, -1, 0, 3, 770, 0, 0};
        repeat (3) @(negedge Clock);
        chk("reset_outputs", {FftAddr, OptStart, OptRe, OptIm, SpcWe, SpcAddr, SpcData,
                              Busy, FrameDone, Overrun, Timeout}, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        for (int r = 0; r < 8; r++) run_frame(r);

        prep(0);
        @(negedge Clock); FrameReady = 1'b1;
        @(negedge Clock); FrameReady = 1'b0;
        cyc = 0;
        while (!(OptStart && FftAddr == 7'd70) && cyc < 5000) begin
            @(negedge Clock); cyc++;
        end
        chk("reach_bin70", cyc < 5000, 1);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        chk("reset_midframe_outputs", {FftAddr, OptStart, OptRe, OptIm, SpcWe, SpcAddr, SpcData,
                                       Busy, FrameDone, Overrun, Timeout}, 0);
        for (int a = 0; a < NA; a++) held[a] = '0;
        wb = wa.size(); sb = st_cnt;
        @(negedge Clock);
        @(negedge Clock); Reset = 1'b0;
        repeat (6) @(negedge Clock);
        chk("no_write_after_reset", wa.size() - wb, 0);
        chk("no_start_after_reset", st_cnt - sb, 0);
        chk("idle_after_reset", Busy, 0);
        run_frame(0);

`ifdef SPC_PEAK_HOLD_EN
        for (int k = 0; k < 3; k++) begin
            peak_b3 = (k == 0) ? 100 : 20;
            run_frame(8);
            chk($sformatf("peak_bin3[%0d]", k), wd[wd.size() - NA + 3], pk[k]);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
